// File: rtl/lh_message_feeder.sv
// lh_message_feeder
//   Initiator side of the light-hash byte interface. Buffers one host message
//   of printable ASCII (8'h20..8'h7E), checks every byte, frames it as
//   HEAD_BYTE / body / TAIL_BYTE towards the hash core, waits for the digest
//   and presents digest plus error code to the host.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both high. in_valid/in_ready: host to feeder. out_valid/out_ready:
//   feeder to host. msg_valid has no back-pressure; the core takes one byte
//   per msg_valid cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_byte/in_valid/in_last/in_ready   host message input
//   msg_byte/msg_valid    framed byte stream to the hash core
//   hash_digest/hash_digest_ready       digest from the hash core
//   out_digest/out_err/out_valid/out_ready   result to host
//     out_err: 00 OK, 01 INVALID_CHAR, 10 OVERFLOW, 11 TIMEOUT
//   dbg_state_o           current FSM state (debug)
//
// Build option: define LH_FEEDER_INTERBYTE_GAP_EN to insert one idle cycle
//   after every framed byte except the tail (frame spans 2N+3 cycles).
module lh_message_feeder #(
   parameter int          DEPTH          = 32,
   parameter logic [7:0]  HEAD_BYTE      = 8'hFF,
   parameter logic [7:0]  TAIL_BYTE      = 8'h00,
   parameter int          TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in_byte,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic [7:0]  msg_byte,
   output logic        msg_valid,
   input  logic [63:0] hash_digest,
   input  logic        hash_digest_ready,
   output logic [63:0] out_digest,
   output logic [1:0]  out_err,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [2:0]  dbg_state_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_LOAD        = 3'd0,
      ST_SEND_HEAD   = 3'd1,
      ST_SEND_BODY   = 3'd2,
      ST_SEND_TAIL   = 3'd3,
      ST_WAIT_DIGEST = 3'd4,
      ST_PRESENT     = 3'd5
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            bad_q, bad_d;
   logic            ovf_q, ovf_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [63:0]     digest_q, digest_d;
   logic [1:0]      err_q, err_d;
   logic [7:0]      mem_q [DEPTH];
   logic            wr_en;
   logic            byte_ok;
`ifdef LH_FEEDER_INTERBYTE_GAP_EN
   logic            gap_q, gap_d;
`endif

   assign byte_ok = (in_byte >= 8'h20) && (in_byte <= 8'h7E);

   // Body storage; contents need no reset since count/pointers qualify them.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= in_byte;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_LOAD;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         bad_q    <= 1'b0;
         ovf_q    <= 1'b0;
         tmr_q    <= '0;
         digest_q <= '0;
         err_q    <= 2'b00;
`ifdef LH_FEEDER_INTERBYTE_GAP_EN
         gap_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         bad_q    <= bad_d;
         ovf_q    <= ovf_d;
         tmr_q    <= tmr_d;
         digest_q <= digest_d;
         err_q    <= err_d;
`ifdef LH_FEEDER_INTERBYTE_GAP_EN
         gap_q    <= gap_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      bad_d     = bad_q;
      ovf_d     = ovf_q;
      tmr_d     = tmr_q;
      digest_d  = digest_q;
      err_d     = err_q;
      wr_en     = 1'b0;
      in_ready  = 1'b0;
      msg_valid = 1'b0;
      msg_byte  = 8'h00;
      out_valid = 1'b0;
`ifdef LH_FEEDER_INTERBYTE_GAP_EN
      gap_d     = gap_q;
`endif

      case (state_q)
         ST_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (!byte_ok) begin
                  bad_d = 1'b1;
               end else if (count_q == CW'(DEPTH)) begin
                  ovf_d = 1'b1;
               end else begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + AW'(1);
                  count_d  = count_q + CW'(1);
               end
               // Error decision includes the flag raised by this very byte.
               if (in_last) begin
                  if (bad_d || ovf_d) begin
                     state_d  = ST_PRESENT;
                     digest_d = '0;
                     err_d    = bad_d ? 2'b01 : 2'b10;
                  end else begin
                     state_d  = ST_SEND_HEAD;
                  end
               end
            end
         end

         ST_SEND_HEAD: begin
            msg_byte = HEAD_BYTE;
`ifdef LH_FEEDER_INTERBYTE_GAP_EN
            if (!gap_q) begin
               msg_valid = 1'b1;
               gap_d     = 1'b1;
            end else begin
               gap_d     = 1'b0;
               state_d   = ST_SEND_BODY;
            end
`else
            msg_valid = 1'b1;
            state_d   = ST_SEND_BODY;
`endif
         end

         ST_SEND_BODY: begin
`ifdef LH_FEEDER_INTERBYTE_GAP_EN
            if (!gap_q) begin
               msg_valid = 1'b1;
               msg_byte  = mem_q[rd_ptr_q];
               rd_ptr_d  = rd_ptr_q + AW'(1);
               count_d   = count_q - CW'(1);
               gap_d     = 1'b1;
            end else begin
               // Idle cycle: hold the byte just issued (read pointer already moved).
               msg_byte  = mem_q[rd_ptr_q - AW'(1)];
               gap_d     = 1'b0;
               if (count_q == '0) state_d = ST_SEND_TAIL;
            end
`else
            msg_valid = 1'b1;
            msg_byte  = mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + AW'(1);
            count_d   = count_q - CW'(1);
            if (count_q == CW'(1)) state_d = ST_SEND_TAIL;
`endif
         end

         ST_SEND_TAIL: begin
            msg_valid = 1'b1;
            msg_byte  = TAIL_BYTE;
            tmr_d     = '0;
            state_d   = ST_WAIT_DIGEST;
         end

         ST_WAIT_DIGEST: begin
            if (hash_digest_ready) begin
               digest_d = hash_digest;
               err_d    = 2'b00;
               state_d  = ST_PRESENT;
            end else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
               digest_d = '0;
               err_d    = 2'b11;
               state_d  = ST_PRESENT;
            end else begin
               tmr_d    = tmr_q + TW'(1);
            end
         end

         ST_PRESENT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d  = ST_LOAD;
               bad_d    = 1'b0;
               ovf_d    = 1'b0;
               count_d  = '0;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
               digest_d = '0;
               err_d    = 2'b00;
            end
         end

         default: state_d = ST_LOAD;
      endcase
   end

   assign out_digest  = digest_q;
   assign out_err     = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lh_message_feeder.sv
`timescale 1ns/1ps
module tb_lh_message_feeder;

   localparam int DEPTH = 32;
   localparam logic [2:0] S_LOAD = 3'd0, S_BODY = 3'd2, S_WAIT = 3'd4;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_byte = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic [7:0]  msg_byte;
   logic        msg_valid;
   logic [63:0] hash_digest = 64'h0;
   logic        hash_digest_ready = 1'b0;
   logic [63:0] out_digest;
   logic [1:0]  out_err;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [2:0]  dbg_state;

   initial forever #5 clk = ~clk;

   lh_message_feeder #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .msg_byte(msg_byte), .msg_valid(msg_valid),
      .hash_digest(hash_digest), .hash_digest_ready(hash_digest_ready),
      .out_digest(out_digest), .out_err(out_err), .out_valid(out_valid),
      .out_ready(out_ready), .dbg_state_o(dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int          errors = 0;
   int          checks = 0;
   logic [7:0]  msg_q[$];
   logic [7:0]  exp_q[$];
   int          cyc = 0;
   int          epoch = 0;
   int          seen_epoch = 0;
   int          got_n = 0;
   logic [7:0]  got_mem [128];
   int          got_cyc [128];

   always @(posedge clk) cyc <= cyc + 1;

   // Byte monitor: records every msg_valid cycle since the last epoch bump.
   always @(negedge clk) begin
      if (seen_epoch != epoch) begin
         seen_epoch = epoch;
         got_n = 0;
      end
      if (rst_n && msg_valid) begin
         if (got_n < 128) begin
            got_mem[got_n] = msg_byte;
            got_cyc[got_n] = cyc;
         end
         got_n++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got=timeout required=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h required=%h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      in_byte  = b;
      in_valid = 1'b1;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_msg();
      for (int i = 0; i < msg_q.size(); i++)
         send_byte(msg_q[i], (i == msg_q.size() - 1));
   endtask

   task automatic new_msg();
      msg_q.delete();
      epoch++;
   endtask

   task automatic expect_frame();
      exp_q.delete();
      exp_q.push_back(8'hFF);
      foreach (msg_q[i]) exp_q.push_back(msg_q[i]);
      exp_q.push_back(8'h00);
   endtask

   function automatic int frame_span(input int n);
`ifdef LH_FEEDER_INTERBYTE_GAP_EN
      return 2 * n + 2;
`else
      return n + 1;
`endif
   endfunction

   task automatic wait_state(input logic [2:0] s, input string tag);
      int n = 0;
      while (dbg_state !== s && n < 300) begin
         tick();
         n++;
      end
      check(tag, {61'h0, dbg_state}, {61'h0, s});
   endtask

   task automatic check_frame(input int n);
      check("frame_cnt", got_n, n + 2);
      for (int i = 0; i < n + 2 && i < 128; i++)
         check($sformatf("msg_byte[%0d]", i), {56'h0, got_mem[i]}, {56'h0, exp_q[i]});
      check("frame_span", got_cyc[n + 1] - got_cyc[0], frame_span(n));
   endtask

   // Sends msg_q as a good message, checks frame, returns digest, checks result.
   task automatic good_msg(input logic [63:0] dig);
      expect_frame();
      send_msg();
      check("head_valid", {63'h0, msg_valid}, 64'd1);
      check("head_byte", {56'h0, msg_byte}, 64'hFF);
      wait_state(S_WAIT, "reach_wait");
      check_frame(msg_q.size());
      hash_digest       = dig;
      hash_digest_ready = 1'b1;
      tick();
      hash_digest_ready = 1'b0;
      check("ok_valid", {63'h0, out_valid}, 64'd1);
      check("ok_digest", out_digest, dig);
      check("ok_err", {62'h0, out_err}, 64'd0);
      check("ok_in_ready", {63'h0, in_ready}, 64'd0);
   endtask

   task automatic bad_msg(input logic [1:0] err, input string tag);
      send_msg();
      check({tag, "_valid"}, {63'h0, out_valid}, 64'd1);
      check({tag, "_err"}, {62'h0, out_err}, {62'h0, err});
      check({tag, "_digest"}, out_digest, 64'd0);
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("hs_valid_low", {63'h0, out_valid}, 64'd0);
      check("hs_load", {61'h0, dbg_state}, {61'h0, S_LOAD});
   endtask

   // ---------------- directed tests ----------------
   initial begin
      int n;

      // reset values
      tick(); tick();
      check("rst_in_ready", {63'h0, in_ready}, 64'd1);
      check("rst_msg_valid", {63'h0, msg_valid}, 64'd0);
      check("rst_msg_byte", {56'h0, msg_byte}, 64'd0);
      check("rst_out_valid", {63'h0, out_valid}, 64'd0);
      check("rst_out_digest", out_digest, 64'd0);
      check("rst_out_err", {62'h0, out_err}, 64'd0);
      rst_n = 1'b1;
      tick();

      // digest_ready outside WAIT_DIGEST is ignored
      hash_digest       = 64'hDEAD_BEEF_0000_0001;
      hash_digest_ready = 1'b1;
      tick(); tick();
      hash_digest_ready = 1'b0;
      check("ign_ready_valid", {63'h0, out_valid}, 64'd0);
      check("ign_ready_state", {61'h0, dbg_state}, {61'h0, S_LOAD});

      // "abc"
      new_msg();
      msg_q = '{8'h61, 8'h62, 8'h63};
      good_msg(64'h0123456789ABCDEF);
      handshake();

      // printable range boundaries
      new_msg();
      msg_q = '{8'h20, 8'h7E};
      good_msg(64'hCAFE_F00D_1234_5678);
      handshake();

      // invalid char, then hold PRESENT with host still offering bytes
      new_msg();
      msg_q = '{8'h41, 8'h7F, 8'h42};
      bad_msg(2'b01, "inv");
      in_byte = 8'h41; in_valid = 1'b1; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_valid", {63'h0, out_valid}, 64'd1);
         check("hold_err", {62'h0, out_err}, 64'd1);
         check("hold_digest", out_digest, 64'd0);
         check("hold_in_ready", {63'h0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      check("rel_valid", {63'h0, out_valid}, 64'd0);
      check("rel_load", {61'h0, dbg_state}, {61'h0, S_LOAD});
      check("rel_in_ready", {63'h0, in_ready}, 64'd1);
      check("inv_no_frame", got_n, 0);

      // FIFO must be empty after an error message
      new_msg();
      msg_q = '{8'h61, 8'h62};
      good_msg(64'h1111_2222_3333_4444);
      handshake();

      // overflow: DEPTH+3 bytes
      new_msg();
      for (int i = 0; i < DEPTH + 3; i++) msg_q.push_back(8'h41);
      bad_msg(2'b10, "ovf");
      check("ovf_no_frame", got_n, 0);
      handshake();

      // exactly DEPTH bytes is fine
      new_msg();
      for (int i = 0; i < DEPTH; i++) msg_q.push_back(8'h41 + 8'(i % 26));
      good_msg(64'hA5A5_5A5A_0F0F_F0F0);
      handshake();

      // bad char has priority over overflow
      new_msg();
      msg_q.push_back(8'h10);
      for (int i = 0; i < DEPTH + 1; i++) msg_q.push_back(8'h41);
      bad_msg(2'b01, "prio");
      check("prio_no_frame", got_n, 0);
      handshake();

      // timeout
      new_msg();
      msg_q = '{8'h78};
      expect_frame();
      send_msg();
      wait_state(S_WAIT, "to_wait");
      n = 0;
      while (!out_valid && n < 200) begin
         tick();
         n++;
      end
      check("to_cycles", n, 64);
      check("to_err", {62'h0, out_err}, 64'd3);
      check("to_digest", out_digest, 64'd0);
      check_frame(1);
      handshake();

      // reset during SEND_BODY of a 10-byte message
      new_msg();
      for (int i = 0; i < 10; i++) msg_q.push_back(8'h30 + 8'(i));
      send_msg();
      tick(); tick(); tick();
      check("mid_body", {61'h0, dbg_state}, {61'h0, S_BODY});
      rst_n = 1'b0;
      #1;
      check("rst_msg_valid_now", {63'h0, msg_valid}, 64'd0);
      check("rst_state_now", {61'h0, dbg_state}, {61'h0, S_LOAD});
      epoch++;
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      check("rst_no_tail", got_n, 0);
      check("rst_in_ready_after", {63'h0, in_ready}, 64'd1);
      check("rst_out_valid_after", {63'h0, out_valid}, 64'd0);

      // clean message after the abort
      new_msg();
      msg_q = '{8'h7A};
      good_msg(64'h0000_0000_0000_0042);
      handshake();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
